safety_interlock: RTL and testbench
===================================

Name: safety_interlock

Overview:
Downstream consumer of the limit checker's fail flags and of the I2C control bits.
Latches and qualifies the fail flags, trips the TA shutdown and removes laser power.
Counts trip events and enforces a clear/hold-off re-arm sequence before power may return.
Sits between the limit checker / I2C slave and the TA_shutdown and laser_pwr_en1_n pins, and runs on the clk_div2 domain.

Parameters:
HOLDOFF_CYCLES, 250000, clk cycles TA shutdown stays asserted after an accepted clear (10 ms at 25 MHz); minimum 2
CNT_W, 8, width of the saturating trip counter

Ports:
clk  in  1  system clock (clk_div2, 25 MHz)
rst  in  1  reset, asynchronous, active-high
enable_error_check  in  1  qualifies all fault inputs; low = faults ignored for tripping and latching
laser_pwr_req  in  1  software power request (static_control[2])
clear_fail  in  1  software clear level (dynamic_control[0]); rising edge is the request
laser_ready  in  1  power-up settle complete
current_limit_fail  in  1  fault bit 0
pulse_lower_limit_fail  in  1  fault bit 1
pulse_upper_limit_fail  in  1  fault bit 2
rate_lower_limit_fail  in  1  fault bit 3
ta_shutdown  out  1  TA shutdown drive, registered
laser_pwr_en  out  1  laser power enable, active-high, registered
fault_latched  out  4  sticky qualified faults since last accepted clear
first_fault  out  4  fault bits present in the cycle that caused the current trip
trip_count  out  CNT_W  saturating count of trip events
clear_ack  out  1  one-cycle pulse when a clear is accepted
state  out  2  current FSM state, for the I2C status register

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE, ta_shutdown=0, laser_pwr_en=0
  - fault_latched=0, first_fault=0, trip_count=0, clear_ack=0
  - clear edge detector history=1, so a clear held high through reset is not a request.
- Qualified fault vector: qf = {rate, upper, lower, current} & {4{enable_error_check}}. Any = |qf.
- Clear request: clear_fail=1 and the previous-cycle sample=0.
- States (encoding in package): IDLE=0, ARMED=1, TRIPPED=2, HOLDOFF=3.
- IDLE:
  - Any -> TRIPPED.
  - Else laser_ready & laser_pwr_req -> ARMED.
- ARMED:
  - Any -> TRIPPED.
  - Else !laser_pwr_req or !laser_ready -> IDLE.
- TRIPPED:
  - Clear request & !Any -> HOLDOFF. On this transition: fault_latched=0, first_fault=0, clear_ack pulses 1 cycle, timer loads HOLDOFF_CYCLES-1.
  - Clear request while Any: ignored, no ack.
- HOLDOFF:
  - Any -> TRIPPED (re-trip).
  - Else at timer==0 -> IDLE.
  - Timer decrements every cycle.
- Entry to TRIPPED, from any state:
  - first_fault <= qf
  - trip_count increments by 1, saturating at all-ones
  - Occurs once per entry, not per cycle.
- fault_latched |= qf every cycle in all states, except the cycle of an accepted clear.
- Outputs are registered from the next-state:
  - ta_shutdown = (next state is TRIPPED or HOLDOFF)
  - laser_pwr_en = (next state is ARMED)
  - Trip latency: fault high at edge N gives ta_shutdown=1 and laser_pwr_en=0 after edge N.
- Boundaries:
  - Simultaneous faults: all bits are captured in first_fault.
  - Fault and clear in the same cycle: the fault wins; stay in TRIPPED, no ack.
  - enable_error_check falling while TRIPPED: remain TRIPPED; a clear is then accepted.
  - laser_pwr_req still high when HOLDOFF expires: go to IDLE, then ARMED on the next cycle (re-arm needs one full IDLE cycle).
  - Reset mid-HOLDOFF: return to IDLE immediately, timer cleared.
- Timer width = clog2(HOLDOFF_CYCLES).

Decomposition:
- Shared package safety_pkg:
  - state localparams ST_IDLE, ST_ARMED, ST_TRIPPED, ST_HOLDOFF
  - fault bit indices FLT_CURRENT=0, FLT_PW_LOW=1, FLT_PW_HIGH=2, FLT_RATE=3
  - NUM_FAULTS=4
- Sub-module holdoff_timer: load/terminal-count down-counter, parameter HOLDOFF_CYCLES.
- Top-level integration: TA_shutdown and laser_pwr_en1_n (= !laser_pwr_en) are driven from this block instead of from static_control and the raw fail flags.

Test Plan:
1. Reset, then enable_error_check=1, laser_ready=1, laser_pwr_req=1 -> state=ARMED and laser_pwr_en=1 two cycles after reset release; ta_shutdown=0.
2. In ARMED, pulse_upper_limit_fail=1 for 1 cycle -> ta_shutdown=1 and laser_pwr_en=0 at that edge; first_fault=4'b0100; fault_latched=4'b0100; trip_count=1; state stays TRIPPED after the fault clears.
3. current and rate faults asserted in the same cycle -> first_fault=4'b1001, trip_count increments by exactly 1. Then clear_fail pulse while current still high -> no clear_ack, state TRIPPED.
4. Fault gone, clear_fail rising edge (HOLDOFF_CYCLES=16) -> clear_ack 1 cycle, fault_latched=0, ta_shutdown held 16 cycles, then state=IDLE and on the next cycle ARMED.
5. During HOLDOFF, rate_lower_limit_fail=1 -> immediate return to TRIPPED, trip_count+1. Separately, enable_error_check=0 with faults high -> no trip, fault_latched stays 0.
6. Force 260 trips -> trip_count saturates at 255. Assert rst mid-HOLDOFF -> all outputs at reset values asynchronously; a clear_fail held high across reset release gives no clear_ack.

Source files
------------

// File: rtl/safety_pkg.sv
// Shared definitions for the laser safety interlock: state encoding and fault bit map.
package safety_pkg;

  localparam int unsigned NUM_FAULTS = 4;
  localparam int unsigned STATE_W    = 2;

  typedef logic [STATE_W-1:0]    state_t;
  typedef logic [NUM_FAULTS-1:0] fault_vec_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARMED   = 2'd1;
  localparam state_t ST_TRIPPED = 2'd2;
  localparam state_t ST_HOLDOFF = 2'd3;

  localparam int unsigned FLT_CURRENT = 0;
  localparam int unsigned FLT_PW_LOW  = 1;
  localparam int unsigned FLT_PW_HIGH = 2;
  localparam int unsigned FLT_RATE    = 3;

  // True when any fault bit of the vector is set.
  function automatic logic fault_any(input fault_vec_t f);
    return |f;
  endfunction

endpackage

// File: rtl/holdoff_timer.sv
// Re-arm hold-off down-counter: loads HOLDOFF_CYCLES-1, counts down while running, flags zero.
module holdoff_timer #(
  parameter int unsigned HOLDOFF_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic zero_c
);

  localparam int unsigned TW = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(HOLDOFF_CYCLES - 1);

  logic [TW-1:0] count;

  // Count register: load wins, otherwise decrement toward zero while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (run && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/safety_interlock.sv
// Laser safety interlock: qualifies fault flags, trips TA shutdown, gates laser power,
// counts trips and enforces a clear plus hold-off sequence before power may return.
module safety_interlock
  import safety_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 250000,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_error_check,
  input  logic                  laser_pwr_req,
  input  logic                  clear_fail,
  input  logic                  laser_ready,
  input  logic                  current_limit_fail,
  input  logic                  pulse_lower_limit_fail,
  input  logic                  pulse_upper_limit_fail,
  input  logic                  rate_lower_limit_fail,
  output logic                  ta_shutdown,
  output logic                  laser_pwr_en,
  output logic [NUM_FAULTS-1:0] fault_latched,
  output logic [NUM_FAULTS-1:0] first_fault,
  output logic [CNT_W-1:0]      trip_count,
  output logic                  clear_ack,
  output logic [STATE_W-1:0]    state
);

  state_t     state_q;
  state_t     state_next;
  fault_vec_t raw_c;
  fault_vec_t qf_c;
  logic       any_c;
  logic       clear_q;
  logic       clear_req_c;
  logic       accept_c;
  logic       entry_c;
  logic       tmr_zero_c;
  logic       ta_c;
  logic       pwr_c;
  fault_vec_t latched_c;
  fault_vec_t first_c;
  logic [CNT_W-1:0] count_c;

  // Gather raw fault flags into the package bit map and qualify them with the enable.
  always_comb begin
    raw_c              = '0;
    raw_c[FLT_CURRENT] = current_limit_fail;
    raw_c[FLT_PW_LOW]  = pulse_lower_limit_fail;
    raw_c[FLT_PW_HIGH] = pulse_upper_limit_fail;
    raw_c[FLT_RATE]    = rate_lower_limit_fail;
    qf_c               = raw_c & {NUM_FAULTS{enable_error_check}};
    any_c              = fault_any(qf_c);
  end

  // Clear edge history; resets high so a clear held through reset is not a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_q <= 1'b1;
    end else begin
      clear_q <= clear_fail;
    end
  end

  assign clear_req_c = clear_fail & ~clear_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic; a fault always outranks a clear request.
  always_comb begin
    state_next = state_q;
    accept_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          state_next = ST_TRIPPED;
        end else if (laser_ready && laser_pwr_req) begin
          state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (any_c) begin
          state_next = ST_TRIPPED;
        end else if (!laser_pwr_req || !laser_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_TRIPPED: begin
        if (clear_req_c && !any_c) begin
          state_next = ST_HOLDOFF;
          accept_c   = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (any_c) begin
          state_next = ST_TRIPPED;
        end else if (tmr_zero_c) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode from the next state, plus fault capture and trip counting.
  always_comb begin
    ta_c      = 1'b0;
    pwr_c     = 1'b0;
    entry_c   = 1'b0;
    latched_c = fault_latched | qf_c;
    first_c   = first_fault;
    count_c   = trip_count;
    ta_c      = (state_next == ST_TRIPPED) || (state_next == ST_HOLDOFF);
    pwr_c     = (state_next == ST_ARMED);
    entry_c   = (state_next == ST_TRIPPED) && (state_q != ST_TRIPPED);
    if (accept_c) begin
      latched_c = '0;
      first_c   = '0;
    end
    if (entry_c) begin
      first_c = qf_c;
      if (trip_count != {CNT_W{1'b1}}) begin
        count_c = trip_count + CNT_W'(1);
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ta_shutdown   <= 1'b0;
      laser_pwr_en  <= 1'b0;
      fault_latched <= '0;
      first_fault   <= '0;
      trip_count    <= '0;
      clear_ack     <= 1'b0;
    end else begin
      ta_shutdown   <= ta_c;
      laser_pwr_en  <= pwr_c;
      fault_latched <= latched_c;
      first_fault   <= first_c;
      trip_count    <= count_c;
      clear_ack     <= accept_c;
    end
  end

  assign state = state_q;

  holdoff_timer #(
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) u_holdoff_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (accept_c),
    .run    (state_q == ST_HOLDOFF),
    .zero_c (tmr_zero_c)
  );

endmodule

// File: tb/tb_safety_interlock.sv
// Scoreboard bench for safety_interlock: directed vectors push expected outputs, a monitor compares.
module tb_safety_interlock;

  localparam logic [1:0] I = 2'd0;
  localparam logic [1:0] A = 2'd1;
  localparam logic [1:0] T = 2'd2;
  localparam logic [1:0] H = 2'd3;

  logic       clk;
  logic       rst;
  logic       enable_error_check;
  logic       laser_pwr_req;
  logic       clear_fail;
  logic       laser_ready;
  logic [3:0] flt;
  logic       ta_shutdown;
  logic       laser_pwr_en;
  logic [3:0] fault_latched;
  logic [3:0] first_fault;
  logic [7:0] trip_count;
  logic       clear_ack;
  logic [1:0] state;

  typedef struct {
    logic [95:0] name;
    bit          chk;
    logic [1:0]  st;
    logic        ta;
    logic        pwr;
    logic [3:0]  fl;
    logic [3:0]  ff;
    logic [7:0]  cnt;
    logic        ack;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  safety_interlock #(
    .HOLDOFF_CYCLES(16),
    .CNT_W(8)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .enable_error_check     (enable_error_check),
    .laser_pwr_req          (laser_pwr_req),
    .clear_fail             (clear_fail),
    .laser_ready            (laser_ready),
    .current_limit_fail     (flt[0]),
    .pulse_lower_limit_fail (flt[1]),
    .pulse_upper_limit_fail (flt[2]),
    .rate_lower_limit_fail  (flt[3]),
    .ta_shutdown            (ta_shutdown),
    .laser_pwr_en           (laser_pwr_en),
    .fault_latched          (fault_latched),
    .first_fault            (first_fault),
    .trip_count             (trip_count),
    .clear_ack              (clear_ack),
    .state                  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input exp_t e);
    checks++;
    if (state !== e.st || ta_shutdown !== e.ta || laser_pwr_en !== e.pwr ||
        fault_latched !== e.fl || first_fault !== e.ff || trip_count !== e.cnt ||
        clear_ack !== e.ack) begin
      fails++;
      $display("FAIL %0s: got st=%0d ta=%b pwr=%b fl=%b ff=%b cnt=%0d ack=%b, want st=%0d ta=%b pwr=%b fl=%b ff=%b cnt=%0d ack=%b",
               e.name, state, ta_shutdown, laser_pwr_en, fault_latched, first_fault, trip_count, clear_ack,
               e.st, e.ta, e.pwr, e.fl, e.ff, e.cnt, e.ack);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) compare(e);
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and queue the expected post-edge outputs.
  task automatic cyc(input logic [95:0] nm, input logic en, input logic req, input logic clr,
                     input logic rdy, input logic [3:0] f, input bit chk, input logic [1:0] st,
                     input logic ta, input logic pwr, input logic [3:0] fl, input logic [3:0] ff,
                     input logic [7:0] cnt, input logic ack);
    exp_t e;
    @(negedge clk);
    enable_error_check = en;
    laser_pwr_req      = req;
    clear_fail         = clr;
    laser_ready        = rdy;
    flt                = f;
    e.name = nm; e.chk = chk; e.st = st; e.ta = ta; e.pwr = pwr;
    e.fl = fl; e.ff = ff; e.cnt = cnt; e.ack = ack;
    q.push_back(e);
  endtask

  task automatic check_now(input logic [95:0] nm, input logic [1:0] st, input logic ta,
                           input logic pwr, input logic [3:0] fl, input logic [3:0] ff,
                           input logic [7:0] cnt, input logic ack);
    exp_t e;
    e.name = nm; e.chk = 1'b1; e.st = st; e.ta = ta; e.pwr = pwr;
    e.fl = fl; e.ff = ff; e.cnt = cnt; e.ack = ack;
    compare(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    enable_error_check = 1'b0;
    laser_pwr_req = 1'b0;
    clear_fail = 1'b0;
    laser_ready = 1'b0;
    flt = 4'b0000;
    repeat (2) @(negedge clk);
    check_now("reset", I, 0, 0, 4'b0000, 4'b0000, 8'd0, 0);
    enable_error_check = 1'b1;
    laser_pwr_req = 1'b1;
    laser_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Arm, then single upper-width fault trip.
    cyc("arm",       1, 1, 0, 1, 4'b0000, 1, A, 0, 1, 4'b0000, 4'b0000, 8'd0, 0);
    cyc("arm2",      1, 1, 0, 1, 4'b0000, 1, A, 0, 1, 4'b0000, 4'b0000, 8'd0, 0);
    cyc("trip_up",   1, 1, 0, 1, 4'b0100, 1, T, 1, 0, 4'b0100, 4'b0100, 8'd1, 0);
    cyc("trip_hold", 1, 1, 0, 1, 4'b0000, 1, T, 1, 0, 4'b0100, 4'b0100, 8'd1, 0);

    // Accepted clear, 16-cycle hold-off, one IDLE cycle, then re-arm.
    cyc("clr_acc",   1, 1, 1, 1, 4'b0000, 1, H, 1, 0, 4'b0000, 4'b0000, 8'd1, 1);
    for (int i = 0; i < 15; i++)
      cyc("holdoff", 1, 1, 1, 1, 4'b0000, 1, H, 1, 0, 4'b0000, 4'b0000, 8'd1, 0);
    cyc("hold_exp",  1, 1, 1, 1, 4'b0000, 1, I, 0, 0, 4'b0000, 4'b0000, 8'd1, 0);
    cyc("rearm",     1, 1, 0, 1, 4'b0000, 1, A, 0, 1, 4'b0000, 4'b0000, 8'd1, 0);

    // Simultaneous faults, then clear while a fault is still present.
    cyc("trip_multi", 1, 1, 0, 1, 4'b1001, 1, T, 1, 0, 4'b1001, 4'b1001, 8'd2, 0);
    cyc("clr_flt",    1, 1, 1, 1, 4'b0001, 1, T, 1, 0, 4'b1001, 4'b1001, 8'd2, 0);
    cyc("clr_low",    1, 1, 0, 1, 4'b0000, 1, T, 1, 0, 4'b1001, 4'b1001, 8'd2, 0);
    cyc("clr_acc2",   1, 1, 1, 1, 4'b0000, 1, H, 1, 0, 4'b0000, 4'b0000, 8'd2, 1);

    // Re-trip during hold-off.
    cyc("retrip",      1, 1, 1, 1, 4'b1000, 1, T, 1, 0, 4'b1000, 4'b1000, 8'd3, 0);
    cyc("retrip_hold", 1, 1, 1, 1, 4'b0000, 1, T, 1, 0, 4'b1000, 4'b1000, 8'd3, 0);

    // Checking disabled while tripped: stay tripped, clear accepted, faults ignored.
    cyc("dis_trip", 0, 1, 0, 1, 4'b1111, 1, T, 1, 0, 4'b1000, 4'b1000, 8'd3, 0);
    cyc("dis_clr",  0, 1, 1, 1, 4'b1111, 1, H, 1, 0, 4'b0000, 4'b0000, 8'd3, 1);
    for (int i = 0; i < 15; i++)
      cyc("dis_hold", 0, 1, 1, 1, 4'b1111, 1, H, 1, 0, 4'b0000, 4'b0000, 8'd3, 0);
    cyc("dis_idle", 0, 1, 1, 1, 4'b1111, 1, I, 0, 0, 4'b0000, 4'b0000, 8'd3, 0);
    cyc("dis_arm",  0, 1, 1, 1, 4'b1111, 1, A, 0, 1, 4'b0000, 4'b0000, 8'd3, 0);

    // Trip counter saturation over 260 total trips.
    cyc("arm_trip", 1, 1, 0, 1, 4'b0001, 1, T, 1, 0, 4'b0001, 4'b0001, 8'd4, 0);
    for (int k = 0; k < 256; k++) begin
      cyc("sat_clr",  1, 1, 1, 1, 4'b0000, 0, H, 1, 0, 4'b0000, 4'b0000, 8'd0, 1);
      cyc("sat_trip", 1, 1, 0, 1, 4'b0001, (k >= 249), T, 1, 0, 4'b0001, 4'b0001,
          (k >= 250) ? 8'd255 : 8'd254, 0);
    end

    // Async reset in the middle of hold-off.
    cyc("rst_clr", 1, 1, 1, 1, 4'b0000, 1, H, 1, 0, 4'b0000, 4'b0000, 8'd255, 1);
    for (int i = 0; i < 3; i++)
      cyc("rst_hold", 1, 1, 1, 1, 4'b0000, 0, H, 1, 0, 4'b0000, 4'b0000, 8'd255, 0);
    drain();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_now("async_rst", I, 0, 0, 4'b0000, 4'b0000, 8'd0, 0);

    // Clear held high across reset release is not a request.
    flt = 4'b0001;
    clear_fail = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc("clr_thru_rst",  1, 1, 1, 1, 4'b0000, 1, T, 1, 0, 4'b0001, 4'b0001, 8'd1, 0);
    cyc("clr_thru_rst2", 1, 1, 1, 1, 4'b0000, 1, T, 1, 0, 4'b0001, 4'b0001, 8'd1, 0);
    cyc("clr_low3",      1, 1, 0, 1, 4'b0000, 1, T, 1, 0, 4'b0001, 4'b0001, 8'd1, 0);
    cyc("clr_acc3",      1, 1, 1, 1, 4'b0000, 1, H, 1, 0, 4'b0000, 4'b0000, 8'd1, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
